// File: rtl/tri_bus_slot_sampler.sv
// Receive-side sweep controller for a single wire shared by N_DRV tristate
// drivers. One driver is enabled at a time. Its level is sampled through a
// 2-flop synchronizer after a settle window. An all-off guard gap follows
// every slot. The collected bits are published as one word.
//
// Handshake: start is sampled only in IDLE, with no ready. While busy,
// start is ignored, including in the DONE cycle. valid is a single-cycle
// pulse with no back-pressure. data_out is updated on the same edge that
// raises valid and holds until the next sweep completes.
module tri_bus_slot_sampler #(
  parameter int N_DRV  = 2,
  parameter int SETTLE = 3,
  parameter int GUARD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_DRV-1:0] slot_mask,
  input  logic             bus_in,
  output logic [N_DRV-1:0] en,
  output logic [N_DRV-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int IW   = (N_DRV > 1) ? $clog2(N_DRV) : 1;
  localparam int CMAX = (SETTLE > GUARD) ? SETTLE : GUARD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GUARD = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [N_DRV-1:0] mask_r;
  logic [N_DRV-1:0] shadow;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             s1, s2;

  logic             has_next;
  logic [IW-1:0]    next_idx;
  logic [IW-1:0]    first_idx;

  // Lowest set bit of the incoming mask, and next polled slot above idx.
  always_comb begin
    has_next  = 1'b0;
    next_idx  = idx;
    first_idx = '0;
    for (int i = N_DRV - 1; i >= 0; i--) begin
      if (slot_mask[i]) first_idx = IW'(i);
      if (mask_r[i] && (i > int'(idx))) begin
        has_next = 1'b1;
        next_idx = IW'(i);
      end
    end
  end

  // State register; reset drops the FSM to IDLE, which also kills en at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic: IDLE -> DRIVE/GUARD slots in ascending order -> DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = (slot_mask == '0) ? ST_DONE : ST_DRIVE;
      ST_DRIVE: if (cnt == SETTLE_LAST) state_next = ST_GUARD;
      ST_GUARD: if (cnt == GUARD_LAST) state_next = has_next ? ST_DRIVE : ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Two-flop synchronizer for the asynchronous shared wire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus_in;
      s2 <= s1;
    end
  end

  // Sweep datapath: mask latch, slot index, window counter, shadow and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r   <= '0;
      shadow   <= '0;
      idx      <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_r <= slot_mask;
            shadow <= '0;
            idx    <= first_idx;
            cnt    <= '0;
            // An empty sweep publishes the freshly cleared shadow.
            if (slot_mask == '0) data_out <= '0;
          end
        end
        ST_DRIVE: begin
          if (cnt == SETTLE_LAST) begin
            shadow[idx] <= s2;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            cnt <= '0;
            if (has_next) idx      <= next_idx;
            else          data_out <= shadow;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; enables are only live in DRIVE.
  always_comb begin
    en        = (state == ST_DRIVE) ? (N_DRV'(1) << idx) : '0;
    valid     = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

endmodule
